// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: mixer output width and PWM output-stage states.
package synth_pkg;
    localparam int SAMPLE_W = 12;
    typedef enum logic [1:0] {OFF, ARM, RUN} pwm_state_t;
endpackage

// File: rtl/step_prescaler.sv
// Free-running clock divider: step pulses once every PRESCALE clocks.
module step_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic n_rst,
    output logic step
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            pre_cnt <= '0;
        else if (pre_cnt == LAST)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 1'b1;
    end

    assign step = (pre_cnt == LAST);
endmodule

// File: rtl/pwm_audio_out.sv
// PWM audio output stage: latches one mixer sample per PWM period and drives the
// RC-filtered speaker pin; enable changes only take effect on period boundaries.
//
//   state | meaning
//   OFF   | pin held low, waiting for en
//   ARM   | en seen, waiting for the next period boundary to latch a sample
//   RUN   | pin modulated by duty, new sample latched every period end
module pwm_audio_out
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = synth_pkg::SAMPLE_W,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] mixed_sample,
    output logic                pwm_out,
    output logic                sample_tick,
    output logic                active,
    output logic [SAMPLE_W-1:0] duty
);
    pwm_state_t          state;
    pwm_state_t          state_nxt;
    logic                step;
    logic                period_end;
    logic                latch;
    logic [SAMPLE_W-1:0] pwm_cnt;

    step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .n_rst (n_rst),
        .step  (step)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            pwm_cnt <= '0;
        else if (step)
            pwm_cnt <= pwm_cnt + 1'b1;
    end

    assign period_end = step && (&pwm_cnt);

    // In RUN, en is only looked at on period_end so a period never gets cut short.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            OFF: if (en) state_nxt = ARM;
            ARM: begin
                if (!en) begin
                    state_nxt = OFF;
                end else if (period_end) begin
                    latch     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (period_end) begin
                    if (en) latch = 1'b1;
                    else    state_nxt = OFF;
                end
            end
            default: state_nxt = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= OFF;
            duty        <= '0;
            pwm_out     <= 1'b0;
            sample_tick <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_nxt;
            if (latch) duty <= mixed_sample;
            pwm_out     <= (state == RUN) && (pwm_cnt < duty);
            sample_tick <= latch;
            active      <= (state_nxt == RUN);
        end
    end
endmodule

// File: doc/pwm_audio_out.md
# pwm_audio_out

Audio output stage that consumes the 12-bit summed voice sample from the mixer and drives a single-bit PWM pin to the board's RC low-pass filter. The block holds one latched sample per PWM period, emits a one-cycle `sample_tick` so upstream oscillators and envelopes can advance, and gates enable changes onto period boundaries so no runt pulses reach the speaker.

## Interface
- `SAMPLE_W`, 12: width of `mixed_sample`. PWM period is 2^SAMPLE_W steps.
- `PRESCALE`, 1: clocks per PWM step; must be ≥ 1.
- `clk`  in  1  system clock
- `n_rst`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `en`  in  1  output enable, level-sensitive
- `mixed_sample`  in  SAMPLE_W  unsigned mixer output; sampled only at period end
- `pwm_out`  out  1  PWM audio pin, registered
- `sample_tick`  out  1  one-cycle pulse: new duty latched this cycle
- `active`  out  1  high while state is RUN
- `duty`  out  SAMPLE_W  currently latched sample, for debug and bench checks

## Operation
- Prescaler `pre_cnt` counts 0..PRESCALE-1 and wraps. `step` = (`pre_cnt` == PRESCALE-1).
- `pwm_cnt` (SAMPLE_W bits) increments on `step` and wraps from 2^SAMPLE_W-1 to 0.
- `period_end` = `step` && `pwm_cnt` == all-ones.
- Both counters run continuously from reset in every state.
- States are OFF, ARM and RUN:
  - OFF: if `en`=1, go to ARM next clock.
  - ARM: if `en`=0, go to OFF. If `en`=1 and `period_end`, latch `duty` <= `mixed_sample` and go to RUN.
  - RUN: on `period_end`, if `en`=1, latch `duty` <= `mixed_sample` and stay in RUN. If `en`=0 on `period_end`, go to OFF and leave `duty` unchanged. `en` changes away from `period_end` are ignored in RUN, so the current period always completes.
- `pwm_out` is registered each clock to (state==RUN) && (`pwm_cnt` < `duty`). High time per period is exactly `duty`·PRESCALE clocks.
  - `duty`=0: output stays low for the whole period.
  - `duty`=all-ones: output is low for PRESCALE clocks per period.
- `sample_tick` is registered. It is 1 in the clock after a latch event, i.e. the first clock of the new period. It is never asserted in OFF.
- `mixed_sample` is used as-is, with no scaling or clamping. The mixer saturates its own output.

## Timing
- Reset values: `pre_cnt`=0, `pwm_cnt`=0, `duty`=0, state=OFF, `pwm_out`=0, `sample_tick`=0, `active`=0.
- Reset asserted mid-RUN forces all outputs low asynchronously. After release, the block restarts from OFF.
- Latency from `mixed_sample` to the pin: the value is latched at `period_end`. It affects `pwm_out` from the second clock of the following period.
- Enable latency: `en` rises at clock c, giving ARM at c+1. RUN starts at the first `period_end` at or after c+1. Worst case is 2^SAMPLE_W·PRESCALE+1 clocks.
- Tick spacing in RUN: exactly 2^SAMPLE_W·PRESCALE clocks.
- Simultaneous `en`=0 and `period_end` in ARM: go to OFF, no latch, no tick.
- `active` is registered from state. It rises in the clock state becomes RUN and falls in the clock state becomes OFF.

## Structure
- Shared package `synth_pkg` holds:
  - `localparam SAMPLE_W = 12`, shared with the mixer's output width.
  - `typedef enum logic [1:0] {OFF, ARM, RUN} pwm_state_t`.
- Sub-module `step_prescaler`:
  - Parameter PRESCALE.
  - Ports `clk`, `n_rst`, `step`.
  - Reused by the oscillator block for its own rate divider.
- Top level holds `pwm_cnt`, the FSM, the `duty` register and the output registers.

## Test plan
- Reset, `en`=1, `mixed_sample`=0x800, PRESCALE=1 -> first `sample_tick` at clock 4096 or 4097. Afterwards `pwm_out` is high exactly 2048 of every 4096 clocks and ticks are 4096 apart.
- `mixed_sample`=0x000, then 0xFFF on the next period -> first period has 0 high clocks. The next has 4095 high and 1 low.
- `mixed_sample` switched from 0x100 to 0xC00 mid-period -> current period keeps 256 high clocks. The next period has 3072.
- `en` dropped 100 clocks into a RUN period -> period completes normally, then state is OFF, `pwm_out`=0, no further `sample_tick`, `active` falls at period end.
- `n_rst` pulsed low mid-high-phase -> `pwm_out`, `active` and `duty` go to 0 immediately. With `en` held at 1, the block rearms and resumes after one full period.
- PRESCALE=3, `mixed_sample`=0x010 -> period is 12288 clocks with 48 high clocks, and `sample_tick` comes every 12288 clocks.
